// File: rtl/led_array_pkg.sv
// Shared defaults for the LED array driver and the scan-index width rule.
// The x port carries one extra bit so out-of-range scan values can be represented.
package led_array_pkg;

    localparam int DEF_ROWS = 5;
    localparam int DEF_COLS = 5;
    localparam int DEF_N    = 5;

    function automatic int x_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Column decoder: one-hot of i_in when enabled, all zero when disabled or i_in >= OUT.
// Purely combinational; no handshake.
module decoder_onehot #(
    parameter int WIDTH = 4,
    parameter int OUT   = 5
) (
    input  logic             i_ena,
    input  logic [WIDTH-1:0] i_in,
    output logic [OUT-1:0]   o_out
);

    // Compare at integer width so indices beyond OUT never alias onto a valid column.
    for (genvar k = 0; k < OUT; k++) begin : g_dec
        assign o_out[k] = i_ena && (int'(i_in) == k);
    end

endmodule

// File: rtl/led_array_driver.sv
// Multiplexed LED array scan driver: selects column x and drives that column's row bits.
// One-cycle registered latency; no handshake, caller sequences x.
module led_array_driver
    import led_array_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int N    = DEF_N
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic [ROWS*COLS-1:0]     cells,
    input  logic [x_width(N)-1:0]    x,
    output logic [ROWS-1:0]          rows,
    output logic [COLS-1:0]          cols
);

    localparam int XW = x_width(N);

    if (ROWS < 1 || COLS < 1 || N < COLS) begin : g_param_check
        $error("led_array_driver: need ROWS>=1, COLS>=1 and N>=COLS");
    end

    logic [COLS-1:0] w_col_sel;
    logic [ROWS-1:0] w_row_drv;
    logic [ROWS-1:0] r_rows;
    logic [COLS-1:0] r_cols;

    decoder_onehot #(
        .WIDTH (XW),
        .OUT   (COLS)
    ) u_col_dec (
        .i_ena (ena),
        .i_in  (x),
        .o_out (w_col_sel)
    );

    // AND-OR mux with the one-hot select: a blanked column forces every row low.
    for (genvar r = 0; r < ROWS; r++) begin : g_row_mux
        assign w_row_drv[r] = |(w_col_sel & cells[r*COLS +: COLS]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rows <= '0;
            r_cols <= '0;
        end else begin
            r_rows <= w_row_drv;
            r_cols <= w_col_sel;
        end
    end

    assign rows = r_rows;
    assign cols = r_cols;

endmodule

// File: tb/tb_led_array_driver.sv
// Scoreboarded bench for led_array_driver with a behavioural scan model and LED print model.
module tb_led_array_driver;
    import led_array_pkg::*;

    localparam int ROWS = DEF_ROWS;
    localparam int COLS = DEF_COLS;
    localparam int N    = DEF_N;
    localparam int XW   = x_width(N);
    localparam int NC   = ROWS * COLS;

    typedef struct packed {
        logic [ROWS-1:0] rows;
        logic [COLS-1:0] cols;
    } exp_t;

    logic            clk   = 1'b0;
    logic            rst   = 1'b0;
    logic            ena   = 1'b0;
    logic [NC-1:0]   cells = '0;
    logic [XW-1:0]   x     = '0;
    logic [ROWS-1:0] rows;
    logic [COLS-1:0] cols;
    logic            model_en = 1'b0;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    led_array_driver #(.ROWS(ROWS), .COLS(COLS), .N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .cells (cells),
        .x     (x),
        .rows  (rows),
        .cols  (cols)
    );

    led_array_model #(.ROWS(ROWS), .COLS(COLS)) u_model (
        .clk  (clk),
        .en   (model_en),
        .rows (rows),
        .cols (cols)
    );

    // Expected picture for one scan step, straight from the display rules.
    function automatic exp_t ref_model(input logic e, input logic [NC-1:0] c, input int xi);
        exp_t res;
        res = '0;
        if (e && xi < COLS) begin
            res.cols[xi] = 1'b1;
            for (int r = 0; r < ROWS; r++) res.rows[r] = c[r*COLS + xi];
        end
        return res;
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got rows=%b cols=%b, expected rows=%b cols=%b",
                     name, act.rows, act.cols, req.rows, req.cols);
        end
    endtask

    task automatic drive(input logic e, input logic [NC-1:0] c, input int xi);
        @(negedge clk);
        ena   = e;
        cells = c;
        x     = XW'(xi);
        exp_q.push_back(ref_model(e, c, xi));
    endtask

    // Monitor: every edge the DUT presents a new picture; compare it to the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) check("scoreboard", {rows, cols}, exp_q.pop_front());
    end

    initial begin
        logic [NC-1:0] ones;
        logic [NC-1:0] c;
        ones = '1;

        // Reset asserted from time zero with live inputs: outputs must already be blank.
        ena = 1'b1; cells = ones; x = XW'(2);
        #3;
        check("reset_no_edge", {rows, cols}, '0);
        @(posedge clk); #1;
        check("reset_held_edge", {rows, cols}, '0);
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(ref_model(ena, cells, 2));

        for (int i = 0; i < COLS; i++) drive(1'b0, ones, i);

        c = '0; c[17] = 1'b1;
        for (int i = 0; i < COLS; i++) drive(1'b1, c, i);

        for (int i = 4; i < 8; i++) drive(1'b1, ones, i);

        model_en = 1'b1;
        for (int j = 0; j < ROWS; j++) begin
            for (int i = 0; i < COLS; i++) begin
                c = '0; c[j*COLS + i] = 1'b1;
                for (int xi = 0; xi < COLS; xi++) drive(1'b1, c, xi);
            end
        end
        drive(1'b0, '0, 0);
        model_en = 1'b0;

        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < NC; k++) c[k] = 1'($urandom_range(0, 1));
            drive(($urandom_range(0, 7) != 0), c, int'($urandom_range(0, (1 << XW) - 1)));
        end

        // Reset dropped mid-scan at x=3.
        for (int i = 0; i < 4; i++) drive(1'b1, ones, i);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("midscan_reset_async", {rows, cols}, '0);
        @(posedge clk); #1;
        check("midscan_reset_held", {rows, cols}, '0);
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(ref_model(ena, cells, int'(x)));
        drive(1'b1, ones, 4);
        drive(1'b0, ones, 0);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// Simulation-only picture of the array: prints every LED currently lit.
module led_array_model #(
    parameter int ROWS = 5,
    parameter int COLS = 5
) (
    input logic            clk,
    input logic            en,
    input logic [ROWS-1:0] rows,
    input logic [COLS-1:0] cols
);

    always @(negedge clk) begin
        if (en) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (rows[r] && cols[c]) $display("model: LED (%0d,%0d) lit", r, c);
                end
            end
        end
    end

endmodule
